pw_packet_filter: RTL and testbench
===================================

// Module: pw_packet_filter
// PURPOSE
// - Sits between fe_capture (PM byte stream) and pw_pattern_matcher in the fe_clk domain.
// - Frames the PM stream into USB packets using rxactive, checks the PID byte, and forwards
//   only packets whose PID is enabled in I_pid_mask; others are dropped whole.
// - Truncates over-length packets and keeps saturating passed/dropped packet counters for reg_pw.
// PARAMETERS
// - pMAX_LEN      1027  max bytes forwarded per packet, PID included (1024 data + PID + CRC16)
// - pCOUNT_WIDTH  16    width of O_pass_count / O_drop_count
// PORTS
// - fe_clk         in   1             capture clock; only clock in the block
// - reset_i        in   1             synchronous, active-high reset
// - I_arm          in   1             enable; low forces IDLE
// - I_rxactive     in   1             PHY rxactive; high = inside a packet
// - I_data         in   8             PM byte from fe_capture
// - I_data_valid   in   1             I_data qualifier, one byte per cycle max
// - I_pid_mask     in   16            bit n set = forward packets with PID[3:0]==n
// - O_data         out  8             forwarded byte
// - O_data_valid   out  1             O_data qualifier
// - O_sop          out  1             high with the PID byte of a forwarded packet
// - O_eop          out  1             one-cycle end of forwarded packet
// - O_truncated    out  1             one-cycle pulse with O_eop if bytes were discarded
// - O_pass_count   out  pCOUNT_WIDTH  forwarded packets, saturating
// - O_drop_count   out  pCOUNT_WIDTH  dropped packets (bad PID or masked), saturating
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, byte count 0, arm edge detector 0.
// - States: IDLE, PID, PASS, DROP. Evaluated every fe_clk edge; I_arm low -> IDLE next cycle.
// - IDLE: I_arm & I_rxactive -> PID. Bytes with I_rxactive low are ignored in every state.
// - PID: first valid byte b: PID ok iff b[7:4]==~b[3:0]. ok & I_pid_mask[b[3:0]] -> PASS,
//   forward b with O_sop=1, byte count=1; else -> DROP, drop_count+1 (saturate).
//   I_rxactive low before any byte -> IDLE, no outputs, no counts.
// - PASS: each valid byte forwarded while byte count < pMAX_LEN, count+1; beyond that bytes are
//   discarded and a sticky truncate flag set. I_rxactive low -> IDLE; O_eop=1 next cycle,
//   O_truncated=flag with it, pass_count+1 (saturate), flag cleared.
// - DROP: discard everything; I_rxactive low -> IDLE.
// - Latency: O_data/O_data_valid/O_sop registered, exactly 1 cycle after I_data_valid.
//   O_eop is never concurrent with O_data_valid (rxactive falls >=1 cycle after last byte).
// - Back-to-back: rxactive low for one cycle between packets is sufficient; new packet re-enters PID.
// - I_arm low mid-packet: IDLE next cycle, no O_eop, no count update; partial packet abandoned.
// - Counters: both cleared on I_arm rising edge (registered edge detect); saturate at all-ones.
// - I_pid_mask sampled only on the PID byte; changes mid-packet have no effect on that packet.
// - Byte counter width $clog2(pMAX_LEN+1); never wraps (holds at pMAX_LEN).
// TESTING
// - Armed, mask=16'h0002, packet {E1,01,02} (OUT token) -> out E1(sop),01,02, eop 1 cycle after
//   rxactive falls, pass_count=1, drop_count=0.
// - Same packet with mask=16'h0000 -> no O_data_valid, no eop, drop_count=1.
// - Bad PID byte 8'hE2 with mask=16'hFFFF -> dropped, drop_count=1, nothing forwarded.
// - pMAX_LEN=4, 7-byte DATA0 packet (PID C3, mask bit3) -> 4 bytes out, eop with O_truncated=1.
// - I_arm dropped after 2nd byte of forwarded packet -> no eop, pass_count unchanged; re-arm
//   (rising edge) -> both counters read 0.
// - Counter saturation: force pass_count to 16'hFFFE, send 3 enabled packets -> holds 16'hFFFF.

Source files
------------

// File: rtl/pw_packet_filter.sv
// USB packet filter: frames the PM byte stream by rxactive, forwards PID-enabled packets, drops the rest.
// O_data/O_sop are registered 1 cycle after input; O_eop comes 1 cycle after rxactive falls; no backpressure.
module pw_packet_filter #(
    parameter int pMAX_LEN     = 1027,
    parameter int pCOUNT_WIDTH = 16
) (
    input  logic                    fe_clk,
    input  logic                    reset_i,
    input  logic                    I_arm,
    input  logic                    I_rxactive,
    input  logic [7:0]              I_data,
    input  logic                    I_data_valid,
    input  logic [15:0]             I_pid_mask,
    output logic [7:0]              O_data,
    output logic                    O_data_valid,
    output logic                    O_sop,
    output logic                    O_eop,
    output logic                    O_truncated,
    output logic [pCOUNT_WIDTH-1:0] O_pass_count,
    output logic [pCOUNT_WIDTH-1:0] O_drop_count
);

    localparam int CW = $clog2(pMAX_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PID,
        ST_PASS,
        ST_DROP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    trunc_q, trunc_d;
    logic                    arm_q;
    logic [7:0]              data_q, data_d;
    logic                    vld_q, vld_d;
    logic                    sop_q, sop_d;
    logic                    eop_q, eop_d;
    logic                    trunc_out_q, trunc_out_d;
    logic [pCOUNT_WIDTH-1:0] pass_q, pass_d;
    logic [pCOUNT_WIDTH-1:0] drop_q, drop_d;

    logic byte_in;
    logic pid_ok;
    logic arm_rise;

    assign byte_in  = I_data_valid & I_rxactive;
    assign pid_ok   = (I_data[7:4] == ~I_data[3:0]);
    assign arm_rise = I_arm & ~arm_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        trunc_d     = trunc_q;
        data_d      = data_q;
        vld_d       = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        trunc_out_d = 1'b0;
        pass_d      = pass_q;
        drop_d      = drop_q;

        if (!I_arm) begin
            // Disarm abandons any packet in flight without eop or count update.
            state_d = ST_IDLE;
            cnt_d   = '0;
            trunc_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    trunc_d = 1'b0;
                    if (I_rxactive) begin
                        state_d = ST_PID;
                    end
                end
                ST_PID: begin
                    if (!I_rxactive) begin
                        state_d = ST_IDLE;
                    end else if (byte_in) begin
                        if (pid_ok && I_pid_mask[I_data[3:0]]) begin
                            state_d = ST_PASS;
                            data_d  = I_data;
                            vld_d   = 1'b1;
                            sop_d   = 1'b1;
                            cnt_d   = CW'(1);
                        end else begin
                            state_d = ST_DROP;
                            if (drop_q != '1) begin
                                drop_d = drop_q + pCOUNT_WIDTH'(1);
                            end
                        end
                    end
                end
                ST_PASS: begin
                    if (!I_rxactive) begin
                        state_d     = ST_IDLE;
                        eop_d       = 1'b1;
                        trunc_out_d = trunc_q;
                        trunc_d     = 1'b0;
                        if (pass_q != '1) begin
                            pass_d = pass_q + pCOUNT_WIDTH'(1);
                        end
                    end else if (byte_in) begin
                        if (cnt_q < CW'(pMAX_LEN)) begin
                            data_d = I_data;
                            vld_d  = 1'b1;
                            cnt_d  = cnt_q + CW'(1);
                        end else begin
                            trunc_d = 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (!I_rxactive) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (arm_rise) begin
            pass_d = '0;
            drop_d = '0;
        end
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            arm_q       <= 1'b0;
            data_q      <= '0;
            vld_q       <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            trunc_out_q <= 1'b0;
            pass_q      <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trunc_q     <= trunc_d;
            arm_q       <= I_arm;
            data_q      <= data_d;
            vld_q       <= vld_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            trunc_out_q <= trunc_out_d;
            pass_q      <= pass_d;
            drop_q      <= drop_d;
        end
    end

    assign O_data       = data_q;
    assign O_data_valid = vld_q;
    assign O_sop        = sop_q;
    assign O_eop        = eop_q;
    assign O_truncated  = trunc_out_q;
    assign O_pass_count = pass_q;
    assign O_drop_count = drop_q;

endmodule

// File: tb/tb_pw_packet_filter.sv
// Scoreboarded random/directed bench for pw_packet_filter with a packet-level reference model.
// Small pMAX_LEN and counter width so truncation and saturation are reached in few cycles.
module tb_pw_packet_filter;

    localparam int MAXL = 4;
    localparam int CWID = 4;
    localparam int SAT  = (1 << CWID) - 1;

    logic            fe_clk = 1'b0;
    logic            reset_i;
    logic            I_arm;
    logic            I_rxactive;
    logic [7:0]      I_data;
    logic            I_data_valid;
    logic [15:0]     I_pid_mask;
    logic [7:0]      O_data;
    logic            O_data_valid;
    logic            O_sop;
    logic            O_eop;
    logic            O_truncated;
    logic [CWID-1:0] O_pass_count;
    logic [CWID-1:0] O_drop_count;

    pw_packet_filter #(.pMAX_LEN(MAXL), .pCOUNT_WIDTH(CWID)) dut (
        .fe_clk       (fe_clk),
        .reset_i      (reset_i),
        .I_arm        (I_arm),
        .I_rxactive   (I_rxactive),
        .I_data       (I_data),
        .I_data_valid (I_data_valid),
        .I_pid_mask   (I_pid_mask),
        .O_data       (O_data),
        .O_data_valid (O_data_valid),
        .O_sop        (O_sop),
        .O_eop        (O_eop),
        .O_truncated  (O_truncated),
        .O_pass_count (O_pass_count),
        .O_drop_count (O_drop_count)
    );

    always #5 fe_clk = ~fe_clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       tr;
    } ev_t;

    ev_t        exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         pass_m   = 0;
    int         drop_m   = 0;
    logic [7:0] pb[0:15];

    task automatic tick();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic fill(input logic [7:0] pid);
        pb[0] = pid;
        for (int i = 1; i < 16; i++) pb[i] = 8'($urandom);
    endtask

    task automatic chk_counts(input string nm);
        chk({nm, "_pass"}, 32'(O_pass_count), 32'(pass_m));
        chk({nm, "_drop"}, 32'(O_drop_count), 32'(drop_m));
    endtask

    // Sends pb[0..len-1] as one packet; abort_at >= 0 disarms after that many bytes.
    task automatic send_pkt(input int len, input logic [15:0] mask, input int abort_at);
        logic fwd;
        fwd = (len > 0) && (pb[0][7:4] == ~pb[0][3:0]) && mask[pb[0][3:0]];
        I_pid_mask   = mask;
        I_rxactive   = 1'b1;
        I_data_valid = 1'b0;
        I_data       = 8'($urandom);
        tick();
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) break;
            if ($urandom_range(0, 3) == 0) begin
                I_data_valid = 1'b0;
                I_data       = 8'($urandom);
                tick();
            end
            I_data       = pb[i];
            I_data_valid = 1'b1;
            if (fwd && i < MAXL) exp_q.push_back('{d: pb[i], sop: (i == 0), eop: 1'b0, tr: 1'b0});
            tick();
            I_pid_mask = 16'($urandom);
        end
        I_data_valid = 1'b0;
        if (abort_at >= 0) begin
            I_arm = 1'b0;
            tick();
            I_rxactive = 1'b0;
            tick();
            I_arm = 1'b1;
            tick();
            pass_m = 0;
            drop_m = 0;
        end else begin
            I_rxactive   = 1'b0;
            I_data_valid = 1'($urandom_range(0, 1));
            I_data       = 8'($urandom);
            if (len > 0 && !fwd) drop_m = sat_inc(drop_m);
            if (fwd) begin
                exp_q.push_back('{d: 8'h00, sop: 1'b0, eop: 1'b1, tr: (len > MAXL)});
                pass_m = sat_inc(pass_m);
            end
            tick();
            I_data_valid = 1'b0;
        end
    endtask

    task automatic rearm();
        I_arm = 1'b0;
        tick();
        I_arm = 1'b1;
        tick();
        pass_m = 0;
        drop_m = 0;
    endtask

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge fe_clk);
            if (!reset_i && (O_data_valid || O_eop || O_sop || O_truncated)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual=vld%0b sop%0b eop%0b tr%0b d=%0h required=none",
                             O_data_valid, O_sop, O_eop, O_truncated, O_data);
                end else begin
                    e = exp_q.pop_front();
                    if (O_data_valid !== !e.eop || O_sop !== e.sop || O_eop !== e.eop ||
                        O_truncated !== e.tr || (!e.eop && O_data !== e.d)) begin
                        failures++;
                        $display("FAIL output_event actual=vld%0b sop%0b eop%0b tr%0b d=%0h required=vld%0b sop%0b eop%0b tr%0b d=%0h",
                                 O_data_valid, O_sop, O_eop, O_truncated, O_data,
                                 !e.eop, e.sop, e.eop, e.tr, e.d);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [3:0]  n;
        logic [7:0]  pid;
        int          len;
        int          ab;
        reset_i      = 1'b1;
        I_arm        = 1'b0;
        I_rxactive   = 1'b0;
        I_data       = 8'h00;
        I_data_valid = 1'b0;
        I_pid_mask   = 16'h0000;
        repeat (3) tick();
        chk("rst_data", 32'(O_data), 32'h0);
        chk("rst_vld", 32'(O_data_valid), 32'h0);
        chk("rst_sop_eop_tr", {29'h0, O_sop, O_eop, O_truncated}, 32'h0);
        chk_counts("rst");
        reset_i = 1'b0;
        I_arm   = 1'b1;
        tick();

        // OUT token forwarded
        fill(8'hE1); pb[1] = 8'h01; pb[2] = 8'h02;
        send_pkt(3, 16'h0002, -1);
        chk_counts("out_token");
        // same packet masked off
        send_pkt(3, 16'h0000, -1);
        chk_counts("masked");
        // bad PID check nibble
        fill(8'hE2);
        send_pkt(3, 16'hFFFF, -1);
        chk_counts("bad_pid");
        // over-length DATA0
        fill(8'hC3);
        send_pkt(7, 16'h0008, -1);
        chk_counts("truncate");
        // exactly max length, no truncation
        fill(8'hC3);
        send_pkt(MAXL, 16'h0008, -1);
        chk_counts("exact_max");
        // rxactive pulse without bytes
        send_pkt(0, 16'hFFFF, -1);
        chk_counts("empty");
        // disarm after 2nd byte, then re-arm clears counters
        fill(8'hE1);
        send_pkt(5, 16'h0002, 2);
        chk_counts("abort_rearm");

        // saturation of both counters
        for (int k = 0; k < SAT + 3; k++) begin
            fill(8'hD2);
            send_pkt(2, 16'h0004, -1);
        end
        chk_counts("pass_sat");
        for (int k = 0; k < SAT + 3; k++) begin
            fill(8'hD2);
            send_pkt(2, 16'hFFFB, -1);
        end
        chk_counts("drop_sat");
        rearm();
        chk_counts("rearm_clear");

        for (int k = 0; k < 150; k++) begin
            n = 4'($urandom);
            pid = ($urandom_range(0, 3) != 0) ? {~n, n} : 8'($urandom);
            fill(pid);
            len = $urandom_range(0, 8);
            ab  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : -1;
            send_pkt(len, 16'($urandom), ab);
            chk_counts("rand");
            if ($urandom_range(0, 24) == 0) begin
                rearm();
                chk_counts("rand_rearm");
            end
        end

        repeat (4) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
